// File: rtl/detector_scan_ctrl_if.sv
// Scan controller bus: word handshake, detector link and scan results.
// The master side feeds words and hosts the sequence detector.
// The slave side is the controller.
interface detector_scan_ctrl_if #(
  parameter int WIDTH = 16
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] word_in;
  logic             word_valid;
  logic             word_ready;
  logic             det_x;
  logic             det_z;
  logic             det_rst_n;
  logic [CW-1:0]    match_count;
  logic [WIDTH-1:0] match_pos;
  logic             busy;
  logic             done;

  modport master (
    output word_in, word_valid, det_z,
    input  word_ready, det_x, det_rst_n, match_count, match_pos, busy, done
  );

  modport slave (
    input  word_in, word_valid, det_z,
    output word_ready, det_x, det_rst_n, match_count, match_pos, busy, done
  );
endinterface

// File: rtl/detector_scan_ctrl.sv
// Serialises a parallel word MSB-first into an external registered sequence
// detector. Each detector Z response is collected into a hit count and a
// per-bit hit bitmap.
// Optional macro DET_CLEAR_EN: inserts a one-cycle CLEAR state that holds the
// detector in reset, so every word is scanned from the detector's initial
// state. Without it the detector history carries across words.
module detector_scan_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                CLK,
  input  logic                RST,
  detector_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

`ifdef DET_CLEAR_EN
  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shiftReg_q, shiftReg_d;
  logic [CW-1:0]    bitCnt_q, bitCnt_d;
  logic [CW-1:0]    matchCount_q, matchCount_d;
  logic [WIDTH-1:0] matchPos_q, matchPos_d;
  logic             sampleEn;

  // Next-state logic. Z lags its bit by one edge, so sampling starts in SHIFT
  // cycle 2 and ends in DRAIN. The bitmap shifts left once per sample, so the
  // first bit's response ends up in the MSB.
  always_comb begin
    state_d      = state_q;
    shiftReg_d   = shiftReg_q;
    bitCnt_d     = bitCnt_q;
    matchCount_d = matchCount_q;
    matchPos_d   = matchPos_q;
    sampleEn     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.word_valid) begin
          shiftReg_d   = bus.word_in;
          bitCnt_d     = '0;
          matchCount_d = '0;
          matchPos_d   = '0;
`ifdef DET_CLEAR_EN
          state_d      = CLEAR;
`else
          state_d      = SHIFT;
`endif
        end
      end
`ifdef DET_CLEAR_EN
      CLEAR: begin
        state_d = SHIFT;
      end
`endif
      SHIFT: begin
        shiftReg_d = {shiftReg_q[WIDTH-2:0], 1'b0};
        sampleEn   = (bitCnt_q != '0);
        if (bitCnt_q == CW'(WIDTH - 1)) begin
          state_d = DRAIN;
        end else begin
          bitCnt_d = bitCnt_q + CW'(1);
        end
      end
      DRAIN: begin
        sampleEn = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (sampleEn) begin
      matchPos_d = {matchPos_q[WIDTH-2:0], bus.det_z};
      if (bus.det_z) begin
        matchCount_d = matchCount_q + CW'(1);
      end
    end
  end

  // State and datapath registers; reset aborts any scan without a done pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      shiftReg_q   <= '0;
      bitCnt_q     <= '0;
      matchCount_q <= '0;
      matchPos_q   <= '0;
    end else begin
      state_q      <= state_d;
      shiftReg_q   <= shiftReg_d;
      bitCnt_q     <= bitCnt_d;
      matchCount_q <= matchCount_d;
      matchPos_q   <= matchPos_d;
    end
  end

  assign bus.word_ready  = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.det_x       = (state_q == SHIFT) ? shiftReg_q[WIDTH-1] : 1'b0;
  assign bus.match_count = matchCount_q;
  assign bus.match_pos   = matchPos_q;
`ifdef DET_CLEAR_EN
  assign bus.det_rst_n   = ~(RST | (state_q == CLEAR));
`else
  assign bus.det_rst_n   = ~RST;
`endif
endmodule
